// File: rtl/fp_alu_pkg.sv
// -----------------------------------------------------------------------------
// fp_alu_pkg
// Shared encodings for the FP ALU scheduler:
//   - request op codes (add / sub / mul / illegal)
//   - scheduler FSM state encoding
//   - IEEE-754 single-precision all-ones exponent and an Inf/NaN helper
// -----------------------------------------------------------------------------
package fp_alu_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_ILL = 2'b11
    } fp_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_RESP = 2'd2
    } sched_state_e;

    localparam logic [7:0] FP_EXP_ALL1 = 8'hFF;

    // True when the operand is Inf or NaN (exponent field all ones).
    function automatic logic fp_is_inf_nan(input logic [31:0] f);
        return (f[30:23] == FP_EXP_ALL1);
    endfunction

endpackage

// File: rtl/fp_rr_arb2.sv
// -----------------------------------------------------------------------------
// fp_rr_arb2
// Two-way round-robin arbiter. A single valid requester always wins; when both
// are valid, the requester that was not granted last wins. The preference
// register only moves when the grant is actually accepted.
// Ports:
//   clk     in   clock, rising edge
//   rst_n   in   asynchronous active-low reset (preference -> requester 0)
//   valid   in   [1:0] request valid per requester
//   accept  in   the current grant is taken this cycle
//   grant   out  [1:0] one-hot grant (combinational), 0 when nothing valid
// -----------------------------------------------------------------------------
module fp_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid,
    input  logic       accept,
    output logic [1:0] grant
);

    // 1: requester 1 is preferred on a tie, 0: requester 0 is preferred.
    logic r_prio1;

    always_comb begin
        grant = valid;
        if (valid == 2'b11) begin
            grant = r_prio1 ? 2'b10 : 2'b01;
        end
    end

    // After granting requester 0 the tie goes to requester 1, and vice versa.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio1 <= 1'b0;
        end else if (accept) begin
            r_prio1 <= grant[0];
        end
    end

endmodule

// File: rtl/fp_alu_sched.sv
// -----------------------------------------------------------------------------
// fp_alu_sched
// Two-requester scheduler in front of a shared combinational single-precision
// add/sub/mul datapath. Picks a requester round-robin, registers its operands,
// drives one op strobe for ALU_LAT cycles (multicycle path into the datapath),
// captures the result on the last hold cycle and returns it tagged with the id.
//
// Parameters:
//   ALU_LAT      cycles operands/strobe are held before capture (>= 1)
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   reqN_valid/ready             request handshake, N = 0,1 (ready is combinational)
//   reqN_op/a/b                  op (00 add, 01 sub, 10 mul, 11 illegal), operands
//   alu_n1/alu_n2                registered operands to the datapath
//   alu_add/alu_sub/alu_mul      op strobes, one high during every hold cycle
//   alu_result/alu_result1       datapath add/sub result, mul result
//   rsp_valid/ready              response handshake
//   rsp_id/rsp_data/rsp_exc      requester id, result, Inf/NaN input flag
// Configuration:
//   FP_SCHED_EXC_EN  when defined, rsp_exc reports an Inf/NaN operand captured
//                    at accept; otherwise rsp_exc is constant 0.
// -----------------------------------------------------------------------------
module fp_alu_sched
    import fp_alu_pkg::*;
#(
    parameter int ALU_LAT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [1:0]  req0_op,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [1:0]  req1_op,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic [31:0] alu_n1,
    output logic [31:0] alu_n2,
    output logic        alu_add,
    output logic        alu_sub,
    output logic        alu_mul,
    input  logic [31:0] alu_result,
    input  logic [31:0] alu_result1,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_data,
    output logic        rsp_exc
);

    localparam int               CNT_W    = $clog2(ALU_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ALU_LAT - 1);

    sched_state_e     r_state;
    sched_state_e     w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_n1;
    logic [31:0]      r_n2;
    logic [1:0]       r_op;
    logic             r_id;
    logic [31:0]      r_rsp_data;

    logic [1:0]       w_valid;
    logic [1:0]       w_grant;
    logic             w_idle;
    logic             w_accept;
    logic             w_sel;
    logic [1:0]       w_sel_op;
    logic [31:0]      w_sel_a;
    logic [31:0]      w_sel_b;
    logic             w_last_hold;

    assign w_valid  = {req1_valid, req0_valid};
    assign w_idle   = (r_state == ST_IDLE);
    assign w_accept = w_idle & (|w_valid);

    fp_rr_arb2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .valid  (w_valid),
        .accept (w_accept),
        .grant  (w_grant)
    );

    assign req0_ready = w_idle & w_grant[0];
    assign req1_ready = w_idle & w_grant[1];

    // Selected request fields; only meaningful while w_accept is high.
    assign w_sel    = w_grant[1];
    assign w_sel_op = w_sel ? req1_op : req0_op;
    assign w_sel_a  = w_sel ? req1_a  : req0_a;
    assign w_sel_b  = w_sel ? req1_b  : req0_b;

    assign w_last_hold = (r_state == ST_HOLD) && (r_cnt == CNT_LAST);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- FSM: next state and decoded outputs ----------------
    // Strobes and rsp_valid decode straight from the state register so they
    // fall together with an asynchronous reset.
    always_comb begin
        w_state_next = r_state;
        alu_add      = 1'b0;
        alu_sub      = 1'b0;
        alu_mul      = 1'b0;
        rsp_valid    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    // Illegal ops skip the datapath entirely.
                    w_state_next = (w_sel_op == OP_ILL) ? ST_RESP : ST_HOLD;
                end
            end
            ST_HOLD: begin
                alu_add = (r_op == OP_ADD);
                alu_sub = (r_op == OP_SUB);
                alu_mul = (r_op == OP_MUL);
                if (w_last_hold) begin
                    w_state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ---------------- hold counter ----------------
    // Cleared on accept so it is zero on the first hold cycle; it stops at
    // CNT_LAST, which is the exit point, so it never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= '0;
        end else if ((r_state == ST_HOLD) && !w_last_hold) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // ---------------- operand / op / id registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_n1 <= '0;
            r_n2 <= '0;
            r_op <= '0;
            r_id <= 1'b0;
        end else if (w_accept) begin
            r_n1 <= w_sel_a;
            r_n2 <= w_sel_b;
            r_op <= w_sel_op;
            r_id <= w_sel;
        end
    end

    // ---------------- result capture ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_data <= '0;
        end else if (w_accept && (w_sel_op == OP_ILL)) begin
            r_rsp_data <= '0;
        end else if (w_last_hold) begin
            r_rsp_data <= (r_op == OP_MUL) ? alu_result1 : alu_result;
        end
    end

    assign alu_n1   = r_n1;
    assign alu_n2   = r_n2;
    assign rsp_id   = r_id;
    assign rsp_data = r_rsp_data;

`ifdef FP_SCHED_EXC_EN
    logic r_exc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_exc <= 1'b0;
        end else if (w_accept) begin
            r_exc <= fp_is_inf_nan(w_sel_a) | fp_is_inf_nan(w_sel_b);
        end
    end

    assign rsp_exc = r_exc;
`else
    assign rsp_exc = 1'b0;
`endif

endmodule

// File: tb/tb_fp_alu_sched.sv
// -----------------------------------------------------------------------------
// tb_fp_alu_sched
// Self-checking bench for fp_alu_sched. Two requester streams are fed from
// queues; a transaction-level model predicts grants, latency, strobe usage and
// the returned result. The datapath is a behavioural stand-in driven by the
// DUT's operand/strobe outputs.
// -----------------------------------------------------------------------------
module tb_fp_alu_sched;

    localparam int ALU_LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [1:0]  req0_op, req1_op;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [31:0] alu_n1, alu_n2, alu_result, alu_result1, rsp_data;
    logic        alu_add, alu_sub, alu_mul;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_exc;

    fp_alu_sched #(.ALU_LAT(ALU_LAT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_op     (req0_op),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_op     (req1_op),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .alu_n1      (alu_n1),
        .alu_n2      (alu_n2),
        .alu_add     (alu_add),
        .alu_sub     (alu_sub),
        .alu_mul     (alu_mul),
        .alu_result  (alu_result),
        .alu_result1 (alu_result1),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_data    (rsp_data),
        .rsp_exc     (rsp_exc)
    );

    always #5 clk = ~clk;

    // ---------------- single-precision helpers (normals, truncating) ----------------
    function automatic real f2r(input logic [31:0] f);
        int  e;
        real r;
        e = int'(f[30:23]);
        if (e == 0) return 0.0;
        r = (1.0 + real'(f[22:0]) / 8388608.0) * (2.0 ** real'(e - 127));
        return f[31] ? -r : r;
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        int          e;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return {d[63], 31'd0};
        e = int'(d[62:52]) - 1023 + 127;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    // Behavioural datapath; distinctive filler when no strobe selects it.
    always_comb begin
        alu_result = 32'hDEAD_BEEF;
        if (alu_add)      alu_result = r2f(f2r(alu_n1) + f2r(alu_n2));
        else if (alu_sub) alu_result = r2f(f2r(alu_n1) - f2r(alu_n2));
        alu_result1 = alu_mul ? r2f(f2r(alu_n1) * f2r(alu_n2)) : 32'hBAD0_CAFE;
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            2'd0:    return r2f(f2r(a) + f2r(b));
            2'd1:    return r2f(f2r(a) - f2r(b));
            2'd2:    return r2f(f2r(a) * f2r(b));
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic ref_exc(input logic [31:0] a, input logic [31:0] b);
`ifdef FP_SCHED_EXC_EN
        return (a[30:23] == 8'hFF) || (b[30:23] == 8'hFF);
`else
        return 1'b0;
`endif
    endfunction

    // Requester that should win given the valids and who was granted last.
    function automatic logic [1:0] ref_winner(input logic [1:0] v, input int last);
        if (v == 2'b11) return (last == 0) ? 2'b10 : 2'b01;
        return v;
    endfunction

    function automatic logic [31:0] rnd_f();
        return {1'($urandom_range(0, 1)), 8'($urandom_range(120, 134)), 23'($urandom)};
    endfunction

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } req_t;

    req_t        q0[$];
    req_t        q1[$];
    int          grant_log[$];
    logic [31:0] data_log[$];
    int          id_log[$];

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    bit   req_en = 1'b0;
    bit   rand_ready = 1'b0;

    int          m_last = 1;   // last granted requester; 1 after reset so req0 wins a tie
    bit          pend = 1'b0;
    bit          p_seen = 1'b0;
    int          p_id, p_cyc;
    logic [1:0]  p_op;
    logic [31:0] p_a, p_b;
    int          n_add, n_sub, n_mul;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        req0_valid = req_en && (q0.size() > 0);
        req1_valid = req_en && (q1.size() > 0);
        if (q0.size() > 0) begin req0_op = q0[0].op; req0_a = q0[0].a; req0_b = q0[0].b; end
        else begin req0_op = 2'd0; req0_a = 32'd0; req0_b = 32'd0; end
        if (q1.size() > 0) begin req1_op = q1[0].op; req1_a = q1[0].a; req1_b = q1[0].b; end
        else begin req1_op = 2'd0; req1_a = 32'd0; req1_b = 32'd0; end
    endtask

    task automatic sample(output logic [1:0] hs);
        logic [1:0] v;
        logic [1:0] er;
        int         lat;
        v  = {req1_valid, req0_valid};
        hs = v & {req1_ready, req0_ready};
        er = pend ? 2'b00 : ref_winner(v, m_last);
        chk("req_ready", {30'd0, req1_ready, req0_ready}, {30'd0, er});
        if (!pend) begin
            chk("idle_strobes", {29'd0, alu_add, alu_sub, alu_mul}, 32'd0);
            chk("idle_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        end else begin
            n_add += int'(alu_add);
            n_sub += int'(alu_sub);
            n_mul += int'(alu_mul);
            chk("alu_n1", alu_n1, p_a);
            chk("alu_n2", alu_n2, p_b);
            if (rsp_valid) begin
                if (!p_seen) begin
                    p_seen = 1'b1;
                    lat = (p_op == 2'd3) ? 1 : ALU_LAT + 1;
                    chk("latency", cyc - p_cyc, lat);
                end
                chk("rsp_data", rsp_data, ref_result(p_op, p_a, p_b));
                chk("rsp_id", {31'd0, rsp_id}, p_id);
                chk("rsp_exc", {31'd0, rsp_exc}, {31'd0, ref_exc(p_a, p_b)});
                if (rsp_ready) begin
                    chk("add_cycles", n_add, (p_op == 2'd0) ? ALU_LAT : 0);
                    chk("sub_cycles", n_sub, (p_op == 2'd1) ? ALU_LAT : 0);
                    chk("mul_cycles", n_mul, (p_op == 2'd2) ? ALU_LAT : 0);
                    data_log.push_back(rsp_data);
                    id_log.push_back(int'(rsp_id));
                    pend = 1'b0;
                end
            end
        end
        if (hs != 2'b00) begin
            p_id  = hs[1] ? 1 : 0;
            p_op  = hs[1] ? req1_op : req0_op;
            p_a   = hs[1] ? req1_a  : req0_a;
            p_b   = hs[1] ? req1_b  : req0_b;
            p_cyc = cyc;
            pend  = 1'b1;
            p_seen = 1'b0;
            n_add = 0; n_sub = 0; n_mul = 0;
            m_last = p_id;
            grant_log.push_back(p_id);
            $display("[%0d] accept id=%0d op=%0d a=%h b=%h", cyc, p_id, p_op, p_a, p_b);
        end
    endtask

    task automatic cycle();
        logic [1:0] hs;
        @(negedge clk);
        sample(hs);
        @(posedge clk);
        #1;
        cyc++;
        if (hs[0]) void'(q0.pop_front());
        if (hs[1]) void'(q1.pop_front());
        if (rand_ready) rsp_ready = ($urandom_range(0, 3) != 0);
        drive();
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while ((q0.size() != 0 || q1.size() != 0 || pend) && k < budget) begin
            cycle();
            k++;
        end
        chk("drain_left", q0.size() + q1.size() + int'(pend), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        rsp_ready = 1'b1;
        drive();
        #2;
        // Reset state
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_rsp_id", {31'd0, rsp_id}, 32'd0);
        chk("rst_rsp_exc", {31'd0, rsp_exc}, 32'd0);
        chk("rst_alu_n1", alu_n1, 32'd0);
        chk("rst_alu_n2", alu_n2, 32'd0);
        chk("rst_strobes", {29'd0, alu_add, alu_sub, alu_mul}, 32'd0);
        repeat (3) cycle();
        rst_n = 1'b1;
        req_en = 1'b1;
        cycle();

        // 1: req0 add 1.5 + 2.5
        q0.push_back('{2'd0, 32'h3FC0_0000, 32'h4020_0000});
        drive();
        drain(50);
        chk("t1_data", data_log[$], 32'h4080_0000);
        chk("t1_id", id_log[$], 0);

        // 2: req1 sub 5 - 3
        q1.push_back('{2'd1, 32'h40A0_0000, 32'h4040_0000});
        drive();
        drain(50);
        chk("t2_data", data_log[$], 32'h4000_0000);
        chk("t2_id", id_log[$], 1);

        // 3: simultaneous requests, held valid -> strict alternation from req0
        grant_log.delete();
        data_log.delete();
        q0.push_back('{2'd2, 32'h4000_0000, 32'h4040_0000});
        q0.push_back('{2'd0, rnd_f(), rnd_f()});
        q0.push_back('{2'd1, rnd_f(), rnd_f()});
        q1.push_back('{2'd0, 32'h3F80_0000, 32'h3F80_0000});
        q1.push_back('{2'd2, rnd_f(), rnd_f()});
        q1.push_back('{2'd0, rnd_f(), rnd_f()});
        drive();
        drain(100);
        chk("t3_grants", grant_log.size(), 6);
        for (int i = 0; i < 6 && i < grant_log.size(); i++) chk("t3_grant_order", grant_log[i], i % 2);
        chk("t3_first_data", data_log[0], 32'h40C0_0000);

        // 4: response backpressure for 5 cycles with another request waiting
        rsp_ready = 1'b0;
        q0.push_back('{2'd0, rnd_f(), rnd_f()});
        q1.push_back('{2'd1, rnd_f(), rnd_f()});
        drive();
        for (int k = 0; k < 20 && !p_seen; k++) cycle();
        chk("t4_rsp_seen", {31'd0, p_seen}, 32'd1);
        repeat (5) cycle();
        rsp_ready = 1'b1;
        drain(50);

        // 5: asynchronous reset in the middle of HOLD
        q0.push_back('{2'd0, rnd_f(), rnd_f()});
        drive();
        for (int k = 0; k < 10 && !pend; k++) cycle();
        #2;
        chk("t5_in_hold_add", {31'd0, alu_add}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_strobes", {29'd0, alu_add, alu_sub, alu_mul}, 32'd0);
        chk("t5_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        pend = 1'b0;
        m_last = 1;
        q0.delete();
        q1.delete();
        drive();
        repeat (2) cycle();
        rst_n = 1'b1;
        grant_log.delete();
        q0.push_back('{2'd0, rnd_f(), rnd_f()});
        q1.push_back('{2'd1, rnd_f(), rnd_f()});
        drive();
        drain(50);
        chk("t5_first_grant", grant_log[0], 0);

        // 6: illegal op, then an Inf operand
        q0.push_back('{2'd3, rnd_f(), rnd_f()});
        drive();
        drain(50);
        chk("t6_ill_data", data_log[$], 32'h0);
        q1.push_back('{2'd0, 32'h7F80_0000, 32'h3F80_0000});
        drive();
        drain(50);

        // Random traffic with random response backpressure
        rand_ready = 1'b1;
        for (int i = 0; i < 40; i++) q0.push_back('{2'($urandom_range(0, 3)), rnd_f(), rnd_f()});
        for (int i = 0; i < 24; i++) q1.push_back('{2'($urandom_range(0, 3)), rnd_f(), rnd_f()});
        drive();
        drain(4000);
        rand_ready = 1'b0;
        rsp_ready = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
